// File: rtl/des_key_schedule_if.sv
// Key-schedule request/bank bundle between the round-stack controller and the
// DES key-schedule generator.
interface des_key_schedule_if;
  logic        start;
  logic        decrypt;
  logic [63:0] key_in;
  logic [47:0] round_keys [0:15];
  logic        busy;
  logic        keys_valid;
  logic        done;

  modport master (
    output start, decrypt, key_in,
    input  round_keys, busy, keys_valid, done
  );

  modport slave (
    input  start, decrypt, key_in,
    output round_keys, busy, keys_valid, done
  );
endinterface

// File: rtl/des_key_schedule.sv
// Iterative DES key schedule: one 48-bit round key per clock into a 16-slot
// bank, stored in reversed slot order for decryption.
module des_key_schedule (
  input  logic                 clk,
  input  logic                 rst,
  des_key_schedule_if.slave    bus
);

  // Tables use FIPS 46-3 bit numbering (1 = MSB of the input vector).
  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] o;
    o = '0;
    for (int i = 0; i < 56; i++) begin
      o[55-i] = k[64-PC1[i]];
    end
    return o;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] o;
    o = '0;
    for (int i = 0; i < 48; i++) begin
      o[47-i] = cd[56-PC2[i]];
    end
    return o;
  endfunction

  function automatic logic [27:0] rotl(input logic [27:0] v, input logic two);
    return two ? {v[25:0], v[27:26]} : {v[26:0], v[27]};
  endfunction

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state;
  logic [3:0]  r;
  logic [27:0] c;
  logic [27:0] d;
  logic        dec;
  logic [47:0] keys [0:15];
  logic        busy_q;
  logic        keys_valid_q;
  logic        done_q;

  logic        shift_two;
  logic [27:0] c_nx;
  logic [27:0] d_nx;
  logic [3:0]  slot;

  // Single-bit rounds are 1, 2, 9 and 16 (r = 0, 1, 8, 15); total shift is 28.
  always_comb begin
    shift_two = !((r == 4'd0) || (r == 4'd1) || (r == 4'd8) || (r == 4'd15));
    c_nx      = rotl(c, shift_two);
    d_nx      = rotl(d, shift_two);
    slot      = dec ? (4'd15 - r) : r;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      r            <= 4'd0;
      c            <= '0;
      d            <= '0;
      dec          <= 1'b0;
      busy_q       <= 1'b0;
      keys_valid_q <= 1'b0;
      done_q       <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        keys[i] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            {c, d}       <= pc1(bus.key_in);
            dec          <= bus.decrypt;
            r            <= 4'd0;
            state        <= RUN;
            busy_q       <= 1'b1;
            keys_valid_q <= 1'b0;
          end
        end
        RUN: begin
          c          <= c_nx;
          d          <= d_nx;
          keys[slot] <= pc2({c_nx, d_nx});
          r          <= r + 4'd1;
          if (r == 4'd15) begin
            state        <= IDLE;
            busy_q       <= 1'b0;
            keys_valid_q <= 1'b1;
            done_q       <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < 16; g++) begin : g_bank
    assign bus.round_keys[g] = keys[g];
  end

  assign bus.busy       = busy_q;
  assign bus.keys_valid = keys_valid_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_des_key_schedule.sv
// Directed bench for des_key_schedule using the classic FIPS worked-example key.
module tb_des_key_schedule;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  des_key_schedule_if bus ();

  des_key_schedule dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [63:0] KEY    = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_PF = 64'h123556789ABDDEF0;
  localparam logic [63:0] WEAK0  = 64'h0101010101010101;
  localparam logic [63:0] WEAK1  = 64'hFEFEFEFEFEFEFEFE;

  logic [47:0] exp_k [0:15] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
  };

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_bank(input string tag, input bit use_tab, input bit rev,
                            input logic [47:0] fill);
    logic [47:0] e;
    for (int i = 0; i < 16; i++) begin
      e = use_tab ? (rev ? exp_k[15-i] : exp_k[i]) : fill;
      chk($sformatf("%s_slot%0d", tag, i), {16'h0, bus.round_keys[i]}, {16'h0, e});
    end
  endtask

  // Drives start for exactly one rising edge; returns one negedge after it.
  task automatic start_key(input logic [63:0] k, input bit dec);
    @(negedge clk);
    bus.start   = 1'b1;
    bus.key_in  = k;
    bus.decrypt = dec;
    @(negedge clk);
    bus.start   = 1'b0;
  endtask

  task automatic run_count(output int bc, output int dc);
    bc = 0;
    dc = 0;
    for (int i = 0; i < 24; i++) begin
      if (bus.busy) bc++;
      if (bus.done) dc++;
      @(negedge clk);
    end
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!bus.done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_seen"}, {63'h0, bus.done}, 64'h1);
  endtask

  int bc;
  int dc;

  initial begin
    checks      = 0;
    errors      = 0;
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.decrypt = 1'b0;
    bus.key_in  = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk("rst_busy",  {63'h0, bus.busy},       64'h0);
    chk("rst_valid", {63'h0, bus.keys_valid}, 64'h0);
    chk("rst_done",  {63'h0, bus.done},       64'h0);
    check_bank("rst", 1'b0, 1'b0, 48'h0);

    // Encrypt order, with busy/done cycle accounting.
    start_key(KEY, 1'b0);
    run_count(bc, dc);
    chk("enc_busy_cycles", 64'(bc), 64'd16);
    chk("enc_done_pulses", 64'(dc), 64'd1);
    chk("enc_valid", {63'h0, bus.keys_valid}, 64'h1);
    check_bank("enc", 1'b1, 1'b0, 48'h0);

    start_key(KEY, 1'b1);
    run_count(bc, dc);
    chk("dec_done_pulses", 64'(dc), 64'd1);
    check_bank("dec", 1'b1, 1'b1, 48'h0);

    start_key(WEAK0, 1'b0);
    run_count(bc, dc);
    check_bank("weak0", 1'b0, 1'b0, 48'h000000000000);

    start_key(WEAK1, 1'b0);
    run_count(bc, dc);
    check_bank("weak1", 1'b0, 1'b0, 48'hFFFFFFFFFFFF);

    start_key(KEY_PF, 1'b0);
    run_count(bc, dc);
    check_bank("parity", 1'b1, 1'b0, 48'h0);

    // A second start mid-run with a different key and mode must be ignored.
    start_key(WEAK1, 1'b0);
    start_key(WEAK0, 1'b0);
    start_key(KEY, 1'b0);
    run_count(bc, dc);
    chk("prefill_valid", {63'h0, bus.keys_valid}, 64'h1);
    start_key(KEY, 1'b0);
    repeat (4) @(negedge clk);
    bus.start   = 1'b1;
    bus.key_in  = WEAK1;
    bus.decrypt = 1'b1;
    @(negedge clk);
    bus.start   = 1'b0;
    wait_done("ignore");
    check_bank("ignore", 1'b1, 1'b0, 48'h0);

    // Asynchronous reset in the middle of a run clears everything without an edge.
    start_key(KEY, 1'b1);
    repeat (7) @(negedge clk);
    chk("pre_rst_busy", {63'h0, bus.busy}, 64'h1);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy",  {63'h0, bus.busy},       64'h0);
    chk("arst_valid", {63'h0, bus.keys_valid}, 64'h0);
    chk("arst_done",  {63'h0, bus.done},       64'h0);
    check_bank("arst", 1'b0, 1'b0, 48'h0);
    @(negedge clk);
    rst = 1'b0;
    start_key(KEY, 1'b1);
    run_count(bc, dc);
    chk("post_rst_valid", {63'h0, bus.keys_valid}, 64'h1);
    check_bank("post_rst", 1'b1, 1'b1, 48'h0);

    // Back-to-back: start again in the cycle where done is high.
    start_key(KEY, 1'b0);
    wait_done("b2b_first");
    check_bank("b2b_first", 1'b1, 1'b0, 48'h0);
    bus.start   = 1'b1;
    bus.key_in  = WEAK1;
    bus.decrypt = 1'b0;
    @(negedge clk);
    bus.start   = 1'b0;
    chk("b2b_valid_low", {63'h0, bus.keys_valid}, 64'h0);
    chk("b2b_busy",      {63'h0, bus.busy},       64'h1);
    chk("b2b_done_low",  {63'h0, bus.done},       64'h0);
    wait_done("b2b_second");
    chk("b2b_valid", {63'h0, bus.keys_valid}, 64'h1);
    check_bank("b2b_second", 1'b0, 1'b0, 48'hFFFFFFFFFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/des_key_schedule.md
# des_key_schedule

Iterative DES key-schedule generator that sits directly upstream of the 16-round stack. It expands one 64-bit DES key into the sixteen 48-bit round keys, producing one key per clock. Results go into a register bank that drives the round stack's `round_keys[0:15]` array input. A decrypt mode stores the keys in reverse slot order, so the round stack is reused unchanged for decryption.

## Interface
- Parameters: none. Round count (16), shift schedule and PC-1/PC-2 tables are fixed by FIPS 46-3.
- `clk` input 1: single clock, all state updates on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: request a new schedule; sampled only in IDLE.
- `decrypt` input 1: 0 = encrypt slot order, 1 = reversed slot order; sampled with `start`.
- `key_in` input 64: DES key, bit 63 = FIPS bit 1; parity bits (FIPS 8,16,…,64) ignored; sampled with `start`.
- `round_keys[0:15]` output 48 each: registered round-key bank, bit 47 = PC-2 output bit 1.
- `busy` output 1: high while in RUN.
- `keys_valid` output 1: high when the bank holds a complete schedule for the last accepted key.
- `done` output 1: one-cycle pulse on schedule completion.

## Operation
- State machine IDLE/RUN, 4-bit round counter `r` (0..15), 28-bit registers C and D.
- IDLE + `start`=1 at an edge: {C,D} <= PC-1(`key_in`); latch `decrypt`; `r` <= 0; state <= RUN; `keys_valid` <= 0.
- RUN, each edge:
  - C' = rotl(C,s), D' = rotl(D,s), with s=1 for rounds r∈{0,1,8,15}, else s=2.
  - C <= C', D <= D'.
  - Write PC-2({C',D'}) to slot `r` (encrypt) or slot `15-r` (decrypt).
  - `r` <= r+1.
- RUN with r=15: write as above, state <= IDLE, `keys_valid` <= 1, `done` <= 1 for one cycle.
- Total shift across 16 rounds is 28, so C/D end equal to their loaded values (useful assertion).
- `start` in RUN is ignored: no restart, no queuing. `key_in`/`decrypt` changes during RUN have no effect.
- `start` in the IDLE cycle where `done` is high is accepted normally; `keys_valid` drops at that edge.
- Slots not yet written in a run keep their previous contents. Consumers must gate on `keys_valid`.
- Reset (any time, including mid-RUN): state IDLE, `r`=0, C=D=0, all 16 slots = 0, `busy`=0, `keys_valid`=0, `done`=0, latched decrypt=0.

## Timing
- Start accepted at edge E0; slots written at edges E1..E16 (one per edge, order per mode).
- `busy` high from after E0 through E16.
- `done` and `keys_valid` high after E16; `done` falls after E17.
- Latency start→valid: 16 cycles. Max throughput: one schedule per 17 cycles (start re-asserted in the `done` cycle).
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Key 133457799BBCDFF1, encrypt → after 16 cycles, slot0=1B02EFFC7072, slot1=79AED9DBC9E5, slot15=CB3D8B0E17F5; `done` pulses exactly once; `busy` is high for exactly 16 cycles.
- Same key, decrypt → slot15=1B02EFFC7072, slot14=79AED9DBC9E5, slot0=CB3D8B0E17F5; all slots equal the encrypt bank reversed.
- Weak keys: 0101010101010101 → all slots 000000000000. FEFEFEFEFEFEFEFE → all slots FFFFFFFFFFFF. Flipping only parity bits of 133457799BBCDFF1 → bank unchanged.
- `start` pulsed with a different key at cycle 5 of RUN → ignored; final bank is for the original key. Back-to-back start in the `done` cycle → `keys_valid` low next cycle, second bank correct 16 cycles later.
- `rst` asserted asynchronously mid-RUN (cycle 8) → all outputs and slots clear immediately, without a clock edge. A new start afterwards yields a correct bank.
- End-to-end: feed the bank to the round stack with plaintext 0123456789ABCDEF and key 133457799BBCDFF1 through IP/FP → ciphertext 85E813540F0AB405. Decrypt mode recovers the plaintext.
